alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal: 4..32).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request; sampled only while FSM is IDLE.
REQ-005 Port: op  input  3  opcode: 000 ADD, 001 SUB, 010 ADC, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 MUL.
REQ-006 Port: A  input  WIDTH  operand A, sampled with start.
REQ-007 Port: B  input  WIDTH  operand B, sampled with start.
REQ-008 Port: result  output  WIDTH  registered result, held until next completion.
REQ-009 Port: carryFlag  output  1  registered carry/no-borrow flag.
REQ-010 Port: zeroFlag  output  1  registered, 1 when result is all zeros.
REQ-011 Port: negFlag  output  1  registered, equals result[WIDTH-1].
REQ-012 Port: ovfFlag  output  1  registered signed-overflow flag.
REQ-013 Port: busy  output  1  high while a multi-cycle MUL is in progress.
REQ-014 Port: done  output  1  one-cycle pulse; result and flags valid and updated in the same cycle.

Function
REQ-015 FSM states: IDLE, MUL; start is ignored in MUL (no queuing, no effect on operation in flight).
REQ-016 Single-cycle ops (000-110): at the edge where start=1 is sampled in IDLE, result/flags register and done=1 for the following cycle; FSM stays IDLE; latency 1.
REQ-017 Back-to-back single-cycle starts each produce a done pulse on consecutive cycles.
REQ-018 ADD: result = A+B; carry = bit WIDTH of the sum; ovf = signed overflow.
REQ-019 SUB: result = A+~B+1; carry = carry out (1 = no borrow, A>=B unsigned); ovf = signed overflow.
REQ-020 ADC: result = A+B+carryFlag (current registered value); carry/ovf as ADD.
REQ-021 AND/OR/XOR: bitwise; carry=0, ovf=0.
REQ-022 SHL: result = A<<1, LSB 0; carry = A[WIDTH-1]; ovf=0; B ignored.
REQ-023 zeroFlag and negFlag are derived from the registered result for every op.
REQ-024 MUL: start in IDLE latches A, B, clears accumulator and counter, enters MUL, busy=1 from the next cycle.
REQ-025 MUL: one shift-add iteration per cycle for exactly WIDTH cycles; on the last iteration result = low WIDTH bits of A*B (unsigned), carry = 1 if high WIDTH bits nonzero, ovf=0, done=1 and busy=0 in the next cycle, FSM returns to IDLE.
REQ-026 MUL latency: done asserted exactly WIDTH cycles after the start edge; busy high for WIDTH cycles.
REQ-027 Flags and result change only on a done pulse or reset; held otherwise.
REQ-028 Counter width is ceil(log2(WIDTH))+1; no wrap before completion.

Reset
REQ-029 rst=1 at a clock edge: FSM->IDLE; result, all four flags, busy, done cleared to 0 the next cycle; rst dominates start.
REQ-030 rst during MUL aborts the operation; no done pulse is produced for it.

Configuration
REQ-031 Macro ALU_MUL_EN defined: MUL state, iterative multiplier and busy logic present per REQ-024..026.
REQ-032 ALU_MUL_EN undefined: op 111 is single-cycle (latency 1), result=0, zeroFlag=1, carry/neg/ovf=0; busy tied 0; FSM never leaves IDLE.

Verification (WIDTH=8)
REQ-033 ADD A=0x69 B=0x02 -> one cycle later done=1, result=0x6B, C=0 Z=0 N=0 V=0; then SUB same operands -> 0x67, C=1; SUB A=0x02 B=0x69 -> 0x99, C=0, N=1.
REQ-034 ADD 0xFF+0x01 -> 0x00, C=1, Z=1; next ADC 0x00+0x00 -> 0x01, C=0, Z=0.
REQ-035 ADD 0x7F+0x01 -> 0x80, V=1, N=1; SHL A=0x81 -> 0x02, C=1.
REQ-036 MUL 0x10*0x11 (ALU_MUL_EN) -> busy high 8 cycles, done exactly 8 cycles after start, result=0x10, C=1; a start pulse with ADD in cycle 3 is ignored (no extra done, operands unchanged).
REQ-037 rst asserted in MUL cycle 3 -> next cycle all outputs 0, FSM IDLE, no done; a new ADD start then completes normally.
REQ-038 ALU_MUL_EN undefined: MUL 0x10*0x11 -> done after 1 cycle, result=0x00, Z=1, busy never high.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops plus an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; without it op 111 completes in one cycle with a zero result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             ovfFlag,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_next;
  logic             mul_req;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign accept = (state == IDLE) && start;

  // Single-cycle datapath; op 111 falls to the default and yields zero.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (op == OP_ADC) && carryFlag};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      OP_SUB: begin
        sum     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SHL: begin
        alu_res = {A[MSB-1:0], 1'b0};
        alu_c   = A[MSB];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic               last;

  assign mul_req  = (op == OP_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (state == MUL) && (cnt == CW'(WIDTH - 1));

  // NOTE: operand/accumulator registers are loaded on every MUL start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && mul_req) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    busy <= 1'b0;
    else if (accept && mul_req) busy <= 1'b1;
    else if (last)              busy <= 1'b0;
  end
`else
  assign mul_req = 1'b0;
  assign busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && mul_req) state_next = MUL;
`ifdef ALU_MUL_EN
      MUL:  if (last) state_next = IDLE;
`else
      MUL:  state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Result and flags move only on completion; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
      negFlag   <= 1'b0;
      ovfFlag   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !mul_req) begin
        result    <= alu_res;
        carryFlag <= alu_c;
        zeroFlag  <= (alu_res == '0);
        negFlag   <= alu_res[MSB];
        ovfFlag   <= alu_v;
        done      <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (last) begin
        result    <= acc_next[MSB:0];
        carryFlag <= |acc_next[2*WIDTH-1:WIDTH];
        zeroFlag  <= (acc_next[MSB:0] == '0);
        negFlag   <= acc_next[MSB];
        ovfFlag   <= 1'b0;
        done      <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops plus multi-cycle sequences.
// MUL sequences follow the ALU_MUL_EN build setting.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         carry_flag, zero_flag, neg_flag, ovf_flag, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (a),
    .B        (b),
    .result   (result),
    .carryFlag(carry_flag),
    .zeroFlag (zero_flag),
    .negFlag  (neg_flag),
    .ovfFlag  (ovf_flag),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c, z, n, v;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] res,
                           input logic c, input logic z, input logic n, input logic v,
                           input logic dn, input logic bz);
    check({name, " result"}, 32'(result), 32'(res));
    check({name, " carry"},  32'(carry_flag), 32'(c));
    check({name, " zero"},   32'(zero_flag), 32'(z));
    check({name, " neg"},    32'(neg_flag), 32'(n));
    check({name, " ovf"},    32'(ovf_flag), 32'(v));
    check({name, " done"},   32'(done), 32'(dn));
    check({name, " busy"},   32'(busy), 32'(bz));
  endtask

  // Drive one start at a negedge; outputs are checked at the following negedge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;

    // ADC rows depend on the carry left by the preceding row.
    vecs[0]  = '{3'b000, 8'h69, 8'h02, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 8'h69, 8'h02, 8'h67, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 8'h02, 8'h69, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{3'b110, 8'h81, 8'h55, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'b101, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'b010, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{3'b010, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset: everything cleared, including zeroFlag.
    repeat (2) @(negedge clk);
    check_all("reset", 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                vecs[i].n, vecs[i].v, 1'b1, 1'b0);
    end

    // Held after the pulse; SUB 05-05 left 00, C=1, Z=1.
    @(negedge clk);
    check_all("hold", 8'h00, 1, 1, 0, 0, 0, 0);

    // Back-to-back single-cycle starts.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
    @(negedge clk);
    check_all("b2b first", 8'h02, 0, 0, 0, 0, 1, 0);
    op = 3'b011; a = 8'hC3; b = 8'h81;
    @(negedge clk);
    start = 1'b0;
    check_all("b2b second", 8'h81, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    check("b2b done low", 32'(done), 32'd0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; op = 3'b000; a = 8'h7F; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_all("rst vs start", 8'h00, 0, 0, 0, 0, 0, 0);

`ifdef ALU_MUL_EN
    // MUL 0x10*0x11 with a stray ADD start in busy cycle 3.
    issue(3'b000, 8'h01, 8'h02);
    check_all("pre mul", 8'h03, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 8'h10; b = 8'h11;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = (k == 3);
      op = 3'b000; a = 8'hFF; b = 8'h01;
      check_all($sformatf("mul busy%0d", k), 8'h03, 0, 0, 0, 0, 0, 1);
    end
    start = 1'b0;
    @(negedge clk);
    check_all("mul done", 8'h10, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    check_all("mul after", 8'h10, 1, 0, 0, 0, 0, 0);

    // Abort a MUL with reset in its third busy cycle.
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 8'h0F; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all("mul abort", 8'h00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check($sformatf("abort no done%0d", k), 32'({done, busy}), 32'd0);
    end
    issue(3'b000, 8'h69, 8'h02);
    check_all("add after abort", 8'h6B, 0, 0, 0, 0, 1, 0);
`else
    // Without the multiplier, op 111 is a one-cycle zero result.
    issue(3'b000, 8'hFF, 8'h01);
    check_all("pre mul", 8'h00, 1, 1, 0, 0, 1, 0);
    issue(3'b111, 8'h10, 8'h11);
    check_all("mul off", 8'h00, 0, 1, 0, 0, 1, 0);
    @(negedge clk);
    check_all("mul off after", 8'h00, 0, 1, 0, 0, 0, 0);
    issue(3'b000, 8'h69, 8'h02);
    check_all("add after mul", 8'h6B, 0, 0, 0, 0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
